// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader.
// Contents: FSM state encodings, CRC-8 polynomial/init constants and a
// single-bit CRC update helper used by the serial CRC sub-module.
package ccff_loader_pkg;

    localparam int unsigned STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_SHIFT  = 3'd2;
    localparam state_t ST_VERIFY = 3'd3;
    localparam state_t ST_CHECK  = 3'd4;

    localparam int unsigned CRC_W     = 8;
    localparam logic [7:0]  CRC8_POLY = 8'h07;
    localparam logic [7:0]  CRC8_INIT = 8'h00;

    // One MSB-first step of a non-reflected serial CRC-8.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_loader_crc8.sv
// Serial CRC-8 accumulator (poly 0x07, init 0x00, no reflection, no final XOR).
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clear      - reload the init value (has priority over enable)
//   enable     - fold bit_in into the running CRC this cycle
//   bit_in     - serial data bit
//   crc        - current CRC value
module ccff_crc8
    import ccff_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;

    // Next CRC value
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC8_INIT;
        end else if (enable) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    // CRC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a configuration flip-flop chain from a word stream and verifies it by
// recirculating the chain once while comparing CRC-8 of shifted-in and
// read-back bits.
// Ports:
//   prog_clk, pReset     - clock, asynchronous active-high reset
//   start                - one-cycle load request (honoured only when idle)
//   cfg_data/cfg_valid   - bitstream word (MSB first) and its qualifier
//   cfg_ready            - high while waiting for a word
//   ccff_head/ccff_tail  - serial bit into the chain / out of the chain
//   chain_clk_en         - chain clock-gate enable; chain shifts when high
//   busy                 - high outside IDLE
//   done                 - one-cycle pulse registered from the CHECK cycle
//   error                - sticky verify-mismatch flag, cleared by start
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned LEFT_W = $clog2(DATA_W + 1);

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LEFT_W-1:0]   left_q,    left_d;
    logic [DATA_W-1:0]   word_q,    word_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                clk_en_q,    clk_en_d;
    logic                recirc_q,    recirc_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                error_q,     error_d;

    logic                crc_clr;
    logic                crc_in_en;
    logic                crc_out_en;
    logic [CRC_W-1:0]    crc_in;
    logic [CRC_W-1:0]    crc_out;

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        left_d     = left_q;
        word_d     = word_q;
        error_d    = error_q;
        crc_clr    = 1'b0;
        crc_in_en  = 1'b0;
        crc_out_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    error_d   = 1'b0;
                    bit_cnt_d = '0;
                    crc_clr   = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (cfg_valid) begin
                    word_d  = cfg_data;
                    left_d  = LEFT_W'(DATA_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                crc_in_en = 1'b1;
                word_d    = word_q << 1;
                left_d    = left_q - LEFT_W'(1);
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                // Chain full wins over end-of-word: leftover low bits are dropped.
                if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                    state_d = ST_VERIFY;
                end else if (left_q == LEFT_W'(1)) begin
                    state_d = ST_FETCH;
                end
            end
            ST_VERIFY: begin
                // bit_cnt counts back down to zero across the recirculation pass.
                crc_out_en = 1'b1;
                bit_cnt_d  = bit_cnt_q - CNT_W'(1);
                if (bit_cnt_q == CNT_W'(1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (crc_in != crc_out) begin
                    error_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output flops mirror the next state so the clock-gate enable is glitch-free.
        cfg_ready_d = (state_d == ST_FETCH);
        clk_en_d    = (state_d == ST_SHIFT) || (state_d == ST_VERIFY);
        recirc_d    = (state_d == ST_VERIFY);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_q == ST_CHECK);
    end

    // State and output registers
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            left_q      <= '0;
            word_q      <= '0;
            cfg_ready_q <= 1'b0;
            clk_en_q    <= 1'b0;
            recirc_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            left_q      <= left_d;
            word_q      <= word_d;
            cfg_ready_q <= cfg_ready_d;
            clk_en_q    <= clk_en_d;
            recirc_q    <= recirc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // CRC of bits sent into the head
    ccff_crc8 u_crc_in (
        .clk    (prog_clk),
        .rst    (pReset),
        .clear  (crc_clr),
        .enable (crc_in_en),
        .bit_in (word_q[DATA_W-1]),
        .crc    (crc_in)
    );

    // CRC of bits read back from the tail
    ccff_crc8 u_crc_out (
        .clk    (prog_clk),
        .rst    (pReset),
        .clear  (crc_clr),
        .enable (crc_out_en),
        .bit_in (ccff_tail),
        .crc    (crc_out)
    );

    // Head must sample the tail in the same chain edge during recirculation,
    // so it is a direct mux; it is forced low whenever the chain is not clocked.
    assign ccff_head    = clk_en_q & (recirc_q ? ccff_tail : word_q[DATA_W-1]);
    assign cfg_ready    = cfg_ready_q;
    assign chain_clk_en = clk_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule
